// File: rtl/fsm_input_conditioner.sv
// Conditions the raw x/y sources into clock-synchronous, debounced FSM inputs.
// Each channel has a 2-flop synchronizer, a debounce filter, rise pulses and a glitch counter.
module fsm_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             x_raw,
    input  logic             y_raw,
    input  logic             freeze,
    output logic             x,
    output logic             y,
    output logic             x_rise,
    output logic             y_rise,
    output logic             chg,
    output logic [CNT_W-1:0] x_glitch,
    output logic [CNT_W-1:0] y_glitch
);

    localparam int unsigned      NCH      = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    // Reject parameter sets the counters cannot represent.
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
        $fatal(1, "fsm_input_conditioner: DEBOUNCE_CYCLES must be in 1..255");
    end
    if (CNT_W < 1 || ((DEBOUNCE_CYCLES - 1) >> CNT_W) != 0) begin : g_bad_cnt_w
        $fatal(1, "fsm_input_conditioner: CNT_W too narrow for DEBOUNCE_CYCLES");
    end

    logic [NCH-1:0]            w_raw;
    logic [NCH-1:0]            r_s1;
    logic [NCH-1:0]            r_s2;
    logic [NCH-1:0]            r_out;
    logic [NCH-1:0]            r_rise;
    logic                      r_chg;
    logic [NCH-1:0][CNT_W-1:0] r_cnt;
    logic [NCH-1:0][CNT_W-1:0] r_glitch;

    logic [NCH-1:0]            w_out_nxt;
    logic [NCH-1:0]            w_upd;
    logic [NCH-1:0][CNT_W-1:0] w_cnt_nxt;
    logic [NCH-1:0][CNT_W-1:0] w_glitch_nxt;

    assign w_raw = {y_raw, x_raw};

    // Debounce filter next-state, channel 0 = x, channel 1 = y.
    always_comb begin
        w_out_nxt    = r_out;
        w_upd        = '0;
        w_cnt_nxt    = r_cnt;
        w_glitch_nxt = r_glitch;
        for (int i = 0; i < NCH; i++) begin
            if (freeze) begin
                w_cnt_nxt[i] = '0;
            end else if (r_s2[i] == r_out[i]) begin
                if (r_cnt[i] != '0) begin
                    w_cnt_nxt[i] = '0;
                    if (r_glitch[i] != CNT_SAT) begin
                        w_glitch_nxt[i] = r_glitch[i] + CNT_W'(1);
                    end
                end
            end else if (r_cnt[i] == CNT_LAST) begin
                w_out_nxt[i] = r_s2[i];
                w_cnt_nxt[i] = '0;
                w_upd[i]     = 1'b1;
            end else begin
                w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_s1     <= '0;
            r_s2     <= '0;
            r_out    <= '0;
            r_rise   <= '0;
            r_chg    <= 1'b0;
            r_cnt    <= '0;
            r_glitch <= '0;
        end else begin
            r_s1     <= w_raw;
            r_s2     <= r_s1;
            r_out    <= w_out_nxt;
            r_rise   <= w_upd & w_out_nxt;
            r_chg    <= |w_upd;
            r_cnt    <= w_cnt_nxt;
            r_glitch <= w_glitch_nxt;
        end
    end

    assign x        = r_out[0];
    assign y        = r_out[1];
    assign x_rise   = r_rise[0];
    assign y_rise   = r_rise[1];
    assign chg      = r_chg;
    assign x_glitch = r_glitch[0];
    assign y_glitch = r_glitch[1];

endmodule
